// File: rtl/alu_cmd_queue_if.sv
// Bundle of the command, ALU and result channels around alu_cmd_queue.
// slave is the queue's view; master is the surrounding environment's view.
interface alu_cmd_queue_if #(
    parameter int unsigned CNT_W = 3
);
    // Command channel
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_a;
    logic [5:0]       in_b;
    logic [1:0]       in_opr;

    // ALU side: operands out, combinational result back in
    logic [5:0]       alu_a;
    logic [5:0]       alu_b;
    logic [1:0]       alu_opr;
    logic [6:0]       alu_out;

    // Result channel
    logic             res_valid;
    logic             res_ready;
    logic [6:0]       res_data;
    logic [1:0]       res_opr;

    // Occupancy, excluding the result register
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  in_valid, in_a, in_b, in_opr, alu_out, res_ready,
        output in_ready, alu_a, alu_b, alu_opr, res_valid, res_data, res_opr, fifo_count
    );

    modport master (
        output in_valid, in_a, in_b, in_opr, alu_out, res_ready,
        input  in_ready, alu_a, alu_b, alu_opr, res_valid, res_data, res_opr, fifo_count
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO plus result register in front of a combinational 6-bit ALU.
// The FIFO head drives the ALU; its result is captured into a one-deep output
// register, so producer and consumer can stall independently.
module alu_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic            clk,
    input logic            rst,
    alu_cmd_queue_if.slave bus
);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENTRY_W = 14;

    // Entry layout: {a[5:0], b[5:0], opr[1:0]}
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               res_valid_q;
    logic [6:0]         res_data_q;
    logic [1:0]         res_opr_q;

    logic               empty;
    logic               full;
    logic               push;
    logic               issue;
    logic [ENTRY_W-1:0] head;
    logic [1:0]         head_opr;

    // Handshake decode; in_ready looks only at registered occupancy
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        push     = bus.in_valid && !full;
        issue    = !empty && (!res_valid_q || bus.res_ready);
        head     = mem_q[rd_ptr_q];
        head_opr = empty ? 2'b00 : head[1:0];
    end

    // Occupancy next state: simultaneous push and issue cancel out
    always_comb begin
        count_d = count_q;
        unique case ({push, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Outputs: ALU operands are zero while empty, everything from registered state
    always_comb begin
        bus.in_ready   = !full;
        bus.alu_a      = empty ? 6'd0 : head[13:8];
        bus.alu_b      = empty ? 6'd0 : head[7:2];
        bus.alu_opr    = head_opr;
        bus.res_valid  = res_valid_q;
        bus.res_data   = res_data_q;
        bus.res_opr    = res_opr_q;
        bus.fifo_count = count_q;
    end

    // Command storage; no reset needed since pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_opr};
        end
    end

    // Pointers, count and result register; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_opr_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (issue) begin
                // A consume on the same edge is absorbed by reloading the register
                rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
                res_data_q  <= bus.alu_out;
                res_opr_q   <= head_opr;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue. A behavioural ALU closes the alu_* loop:
//   00: a + 2b   01: a + 3b   10: a - b   11: (a + b) >>> 1   (7-bit result)
module tb_alu_cmd_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;

    alu_cmd_queue_if #(.CNT_W(CNT_W)) bus ();

    alu_cmd_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                             input logic [1:0] op);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic signed [7:0] r;
        sa = {{2{a[5]}}, a};
        sb = {{2{b[5]}}, b};
        case (op)
            2'b00:   r = sa + (sb <<< 1);
            2'b01:   r = sa + sb + (sb <<< 1);
            2'b10:   r = sa - sb;
            default: r = (sa + sb) >>> 1;
        endcase
        return r[6:0];
    endfunction

    assign bus.alu_out = alu_model(bus.alu_a, bus.alu_b, bus.alu_opr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [5:0] a, input logic [5:0] b,
                             input logic [1:0] op);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_opr   = op;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] exp_q [$];
        logic [8:0] exp_e;
        logic       acc;
        logic       con;
        logic [6:0] pre_data;
        logic [1:0] pre_opr;
        int         sent;
        int         got;
        int         cyc;

        // Reset
        rst = 1'b1;
        drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
        bus.res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_opr", 32'(bus.res_opr), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);

        // Single command: 1 + 2*2 = 5
        drive_cmd(1'b1, 6'd1, 6'd2, 2'b00);
        bus.res_ready = 1'b1;
        tick();
        drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
        check("one_alu_a", 32'(bus.alu_a), 32'd1);
        check("one_alu_b", 32'(bus.alu_b), 32'd2);
        check("one_alu_opr", 32'(bus.alu_opr), 32'd0);
        check("one_count", 32'(bus.fifo_count), 32'd1);
        check("one_no_bypass", 32'(bus.res_valid), 32'd0);
        tick();
        check("one_res_valid", 32'(bus.res_valid), 32'd1);
        check("one_res_data", 32'(bus.res_data), 32'd5);
        check("one_res_opr", 32'(bus.res_opr), 32'd0);
        check("one_empty_alu_a", 32'(bus.alu_a), 32'd0);
        tick();
        check("one_consumed", 32'(bus.res_valid), 32'd0);
        check("one_data_hold", 32'(bus.res_data), 32'd5);

        // Streaming: 1+6=7, 0-3=-3, (1+5)>>>1=3
        drive_cmd(1'b1, 6'd1, 6'd2, 2'b01);
        tick();
        drive_cmd(1'b1, 6'd0, 6'd3, 2'b10);
        tick();
        check("str0_valid", 32'(bus.res_valid), 32'd1);
        check("str0_data", 32'(bus.res_data), 32'h07);
        check("str0_opr", 32'(bus.res_opr), 32'd1);
        drive_cmd(1'b1, 6'd1, 6'd5, 2'b11);
        tick();
        check("str1_valid", 32'(bus.res_valid), 32'd1);
        check("str1_data", 32'(bus.res_data), 32'h7D);
        check("str1_opr", 32'(bus.res_opr), 32'd2);
        drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
        tick();
        check("str2_valid", 32'(bus.res_valid), 32'd1);
        check("str2_data", 32'(bus.res_data), 32'h03);
        check("str2_opr", 32'(bus.res_opr), 32'd3);
        tick();
        check("str_drained", 32'(bus.res_valid), 32'd0);
        check("str_count", 32'(bus.fifo_count), 32'd0);

        // Backpressure: c0 into result register, c1..c4 fill the FIFO
        bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_cmd(1'b1, 6'(k + 1), 6'(k), 2'(k));
            tick();
        end
        drive_cmd(1'b1, 6'd6, 6'd5, 2'd1);
        check("full_count", 32'(bus.fifo_count), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_res_valid", 32'(bus.res_valid), 32'd1);
        check("full_res_data", 32'(bus.res_data), 32'(alu_model(6'd1, 6'd0, 2'd0)));

        // Stall: inputs keep changing, result and head stay put
        for (int s = 0; s < 5; s++) begin
            drive_cmd(1'b1, 6'(10 + s), 6'(20 + s), 2'(s));
            tick();
            check("stall_data", 32'(bus.res_data), 32'd1);
            check("stall_opr", 32'(bus.res_opr), 32'd0);
            check("stall_head_a", 32'(bus.alu_a), 32'd2);
            check("stall_head_opr", 32'(bus.alu_opr), 32'd1);
            check("stall_count", 32'(bus.fifo_count), 32'd4);
        end
        drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
        bus.res_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("drain_valid", 32'(bus.res_valid), 32'd1);
            check("drain_data", 32'(bus.res_data), 32'(alu_model(6'(k + 1), 6'(k), 2'(k))));
            check("drain_opr", 32'(bus.res_opr), 32'(k[1:0]));
        end
        tick();
        check("drain_done", 32'(bus.res_valid), 32'd0);
        check("drain_count", 32'(bus.fifo_count), 32'd0);

        // Wrap-around: 10 random commands, random res_ready, scoreboarded
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 10 && cyc < 300) begin
            if (sent < 10) begin
                drive_cmd(1'b1, 6'($urandom), 6'($urandom), 2'($urandom));
            end else begin
                drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
            end
            bus.res_ready = 1'($urandom_range(0, 1));
            acc      = bus.in_valid && bus.in_ready;
            con      = bus.res_valid && bus.res_ready;
            pre_data = bus.res_data;
            pre_opr  = bus.res_opr;
            if (acc) begin
                exp_q.push_back({alu_model(bus.in_a, bus.in_b, bus.in_opr), bus.in_opr});
                sent++;
            end
            tick();
            cyc++;
            if (con) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $error("FAIL wrap_extra: observed result %0h, expected none", pre_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wrap_result", 32'({pre_data, pre_opr}), 32'(exp_e));
                end
                got++;
            end
        end
        check("wrap_got", 32'(got), 32'd10);
        check("wrap_sent", 32'(sent), 32'd10);
        check("wrap_count", 32'(bus.fifo_count), 32'd0);
        check("wrap_idle", 32'(bus.res_valid), 32'd0);

        // Reset mid-operation: 3 queued, result held, push in flight
        drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
        bus.res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(1'b1, 6'(k), 6'(k + 3), 2'(k));
            tick();
        end
        check("pre_rst_count", 32'(bus.fifo_count), 32'd3);
        check("pre_rst_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        drive_cmd(1'b1, 6'd7, 6'd7, 2'd1);
        bus.res_ready = 1'b1;
        tick();
        rst = 1'b0;
        drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_data", 32'(bus.res_data), 32'd0);
        check("mid_rst_opr", 32'(bus.res_opr), 32'd0);
        check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("mid_rst_no_stale", 32'(bus.res_valid), 32'd0);
        end

        // Recovery: 2 - 1 = 1
        drive_cmd(1'b1, 6'd2, 6'd1, 2'b10);
        tick();
        drive_cmd(1'b0, 6'd0, 6'd0, 2'd0);
        check("post_rst_count", 32'(bus.fifo_count), 32'd1);
        tick();
        check("post_rst_valid", 32'(bus.res_valid), 32'd1);
        check("post_rst_data", 32'(bus.res_data), 32'd1);
        check("post_rst_opr", 32'(bus.res_opr), 32'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
Command buffer and result register that sits directly upstream of the 6-bit ALU. It accepts (A, B, opr) commands over a valid/ready handshake and queues them in a small FIFO. It presents the head command to the combinational ALU and captures the ALU's 7-bit result into an output register. The result is returned with its opcode over a second valid/ready handshake, so producer and consumer can stall independently.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
CNT_W, 3, width of the occupancy count; must hold 0..DEPTH

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  command offered this cycle
in_ready  output  1  command FIFO can accept
in_a  input  6  operand A, signed two's complement
in_b  input  6  operand B, signed two's complement
in_opr  input  2  ALU opcode 00..11
alu_a  output  6  operand A driven to the ALU
alu_b  output  6  operand B driven to the ALU
alu_opr  output  2  opcode driven to the ALU
alu_out  input  7  ALU result, signed; combinational from alu_a/alu_b/alu_opr
res_valid  output  1  result register holds an unconsumed result
res_ready  input  1  downstream accepts result
res_data  output  7  captured ALU result, signed
res_opr  output  2  opcode that produced res_data
fifo_count  output  CNT_W  commands currently queued, excluding the result register

Behaviour:
- Reset (rst=1 at rising edge):
  - FIFO read and write pointers and fifo_count go to 0.
  - res_valid=0, res_data=0, res_opr=0.
  - Reset overrides every other event in the same cycle, including a push/pop mid-handshake; the in-flight command is dropped.
- Push:
  - in_ready = (fifo_count != DEPTH). It depends only on registered state, not on a same-cycle pop.
  - On an edge with in_valid && in_ready, {in_a, in_b, in_opr} is written at the write pointer and the write pointer increments, wrapping mod DEPTH.
- ALU drive:
  - alu_a, alu_b and alu_opr equal the FIFO head entry whenever fifo_count != 0.
  - They are all-zero when the FIFO is empty.
  - These outputs are purely combinational from registered state (no input-to-output path).
- Issue/pop:
  - issue = (fifo_count != 0) && (!res_valid || res_ready).
  - On an issue edge: res_data <= alu_out, res_opr <= alu_opr, res_valid <= 1, and the read pointer increments, wrapping.
- Result consume:
  - On an edge with res_valid && res_ready and no issue, res_valid <= 0; res_data and res_opr hold their values.
  - A consume and an issue on the same edge load the new result with res_valid staying 1. This gives back-to-back throughput of one result per cycle.
  - While res_valid && !res_ready, res_data and res_opr are stable and no issue occurs.
- Count:
  - fifo_count increments on push-only, decrements on issue-only, and is unchanged on simultaneous push and issue.
  - Push and issue on the same edge are legal at any occupancy from 1 to DEPTH-1.
  - When full, no push is accepted even if an issue happens on the same edge.
- Empty FIFO: a push at edge N makes the command the head after N. It issues at edge N+1 if the result register is free, and res_valid rises after N+1. Minimum latency from acceptance to res_valid is 2 edges; there is no bypass.
- Width: res_data is alu_out taken verbatim (7-bit signed, sign extension already done by the ALU). The block performs no arithmetic.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by fifo_count only.

Test Plan:
- Single command: push A=1, B=2, opr=00 into an empty queue, res_ready=1. Expect alu_* = 1/2/00 after the push edge; res_valid=1, res_data=5, res_opr=00 one edge later; then res_valid=0.
- Streaming: push opr=01 A=1 B=2, then opr=10 B=3, then opr=11 A=1 B=5 on consecutive cycles with res_ready=1. Expect results 7, -3 (7'h7D), 3 on consecutive cycles, in order, each with its matching res_opr.
- Backpressure/full: hold res_ready=0 and push 6 commands with DEPTH=4. Expect the first to be issued into the result register, the next 4 to fill the FIFO, in_ready=0 with fifo_count=4, and the 6th held off. Raise res_ready and expect all 5 results in order with none lost or duplicated.
- Stall stability: while res_valid=1 and res_ready=0 for 5 cycles, change in_* and push. Expect res_data and res_opr unchanged, and alu_* still showing the FIFO head.
- Wrap-around: run 10 commands through DEPTH=4 with random res_ready. Scoreboard all results against a reference ALU model; expect pointers wrapping and no mismatch.
- Reset mid-operation: assert rst for one cycle with 3 commands queued and res_valid=1. Expect res_valid=0, res_data=0, fifo_count=0 and in_ready=1 on the next cycle, and no stale result emitted afterwards.
